// File: rtl/snake_tile_map_ctrl.sv
// Tile-occupancy map for the snake board: renderer queries win the single map port,
// game writes and clear sweeps use query-free cycles. Optional occupancy count: SNAKE_TILE_OCC_COUNT_EN.
module snake_tile_map_ctrl #(
    parameter int unsigned GRID_W  = 10,
    parameter int unsigned GRID_H  = 10,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_done,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic               upd_op,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [1:0]         upd_tile,
    input  logic               qry_valid,
    input  logic [COORD_W-1:0] qry_x,
    input  logic [COORD_W-1:0] qry_y,
    output logic [1:0]         qry_tile,
    output logic               qry_tile_valid,
    output logic               busy,
    output logic               clear_done,
    output logic               err_oob,
    output logic [CNT_W-1:0]   occ_count
);

    localparam int unsigned N_TILES = GRID_W * GRID_H;
    localparam int unsigned ADDR_W  = $clog2(N_TILES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TILES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (32'(x) < GRID_W) && (32'(y) < GRID_H);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

    logic [1:0]        map_mem [N_TILES];

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;
    logic              clr_pending, clr_pending_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [1:0]        wr_tile, wr_tile_n;
    logic              game_done_d;
    logic              gd_rise;
    logic              busy_n, clear_done_n, err_oob_n;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [1:0]        mem_wdata;
    logic              qry_hit;
    logic [ADDR_W-1:0] qry_addr;
`ifdef SNAKE_TILE_OCC_COUNT_EN
    logic              wr_phase, wr_phase_n;
    logic [1:0]        old_tile, old_tile_n;
    logic [CNT_W-1:0]  occ_n;
`endif

    assign gd_rise  = game_done & ~game_done_d;
    assign qry_hit  = in_range(qry_x, qry_y);
    assign qry_addr = tile_addr(qry_x, qry_y);

    // Left combinational so a game_done edge can veto an update in the same cycle.
    assign upd_ready = (state == ST_IDLE) && !clr_pending && !gd_rise;

    // Next-state, map write port and pulse generation.
    always_comb begin
        state_n       = state;
        clr_ptr_n     = clr_ptr;
        clr_pending_n = clr_pending;
        wr_addr_n     = wr_addr;
        wr_tile_n     = wr_tile;
        clear_done_n  = 1'b0;
        err_oob_n     = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr;
        mem_wdata     = wr_tile;
`ifdef SNAKE_TILE_OCC_COUNT_EN
        wr_phase_n    = wr_phase;
        old_tile_n    = old_tile;
        occ_n         = occ_count;
`endif
        case (state)
            ST_IDLE: begin
                if (clr_pending || gd_rise) begin
                    state_n       = ST_CLEAR;
                    clr_ptr_n     = '0;
                    clr_pending_n = 1'b0;
                end else if (upd_valid) begin
                    if (upd_op) begin
                        state_n   = ST_CLEAR;
                        clr_ptr_n = '0;
                    end else if (in_range(upd_x, upd_y)) begin
                        wr_addr_n = tile_addr(upd_x, upd_y);
                        wr_tile_n = upd_tile;
                        state_n   = ST_WRITE;
`ifdef SNAKE_TILE_OCC_COUNT_EN
                        wr_phase_n = 1'b0;
`endif
                    end else begin
                        err_oob_n = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (gd_rise) clr_pending_n = 1'b1;
                if (!qry_valid) begin
`ifdef SNAKE_TILE_OCC_COUNT_EN
                    if (!wr_phase) begin
                        old_tile_n = map_mem[wr_addr];
                        wr_phase_n = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        state_n    = ST_IDLE;
                        wr_phase_n = 1'b0;
                        if (old_tile == 2'd0 && wr_tile != 2'd0)
                            occ_n = occ_count + CNT_W'(1);
                        else if (old_tile != 2'd0 && wr_tile == 2'd0)
                            occ_n = occ_count - CNT_W'(1);
                    end
`else
                    mem_we  = 1'b1;
                    state_n = ST_IDLE;
`endif
                end
            end
            ST_CLEAR: begin
                if (!qry_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_ptr;
                    mem_wdata = 2'd0;
                end
                if (gd_rise) begin
                    clr_ptr_n = '0;
                end else if (!qry_valid) begin
                    if (clr_ptr == LAST_ADDR) begin
                        state_n      = ST_IDLE;
                        clear_done_n = 1'b1;
`ifdef SNAKE_TILE_OCC_COUNT_EN
                        occ_n        = '0;
`endif
                    end else begin
                        clr_ptr_n = clr_ptr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_n   = ST_CLEAR;
                clr_ptr_n = '0;
            end
        endcase
        busy_n = (state_n != ST_IDLE) || clr_pending_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            clr_pending <= 1'b0;
            wr_addr     <= '0;
            wr_tile     <= 2'd0;
            game_done_d <= 1'b0;
            busy        <= 1'b1;
            clear_done  <= 1'b0;
            err_oob     <= 1'b0;
`ifdef SNAKE_TILE_OCC_COUNT_EN
            wr_phase    <= 1'b0;
            old_tile    <= 2'd0;
            occ_count   <= '0;
`endif
        end else begin
            state       <= state_n;
            clr_ptr     <= clr_ptr_n;
            clr_pending <= clr_pending_n;
            wr_addr     <= wr_addr_n;
            wr_tile     <= wr_tile_n;
            game_done_d <= game_done;
            busy        <= busy_n;
            clear_done  <= clear_done_n;
            err_oob     <= err_oob_n;
`ifdef SNAKE_TILE_OCC_COUNT_EN
            wr_phase    <= wr_phase_n;
            old_tile    <= old_tile_n;
            occ_count   <= occ_n;
`endif
        end
    end

`ifndef SNAKE_TILE_OCC_COUNT_EN
    assign occ_count = '0;
`endif

    // Map storage; contents are established by the clear sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) map_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qry_tile       <= 2'd0;
            qry_tile_valid <= 1'b0;
        end else begin
            qry_tile_valid <= qry_valid;
            if (qry_valid) qry_tile <= qry_hit ? map_mem[qry_addr] : 2'd0;
        end
    end

endmodule

// File: tb/tb_snake_tile_map_ctrl.sv
// Scoreboard bench for snake_tile_map_ctrl: queries push expected tiles, a monitor pops them.
module tb_snake_tile_map_ctrl;

`ifdef SNAKE_TILE_OCC_COUNT_EN
    localparam int W_CYC  = 2;
    localparam bit OCC_EN = 1'b1;
`else
    localparam int W_CYC  = 1;
    localparam bit OCC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       game_done;
    logic       upd_valid;
    logic       upd_ready;
    logic       upd_op;
    logic [3:0] upd_x, upd_y;
    logic [1:0] upd_tile;
    logic       qry_valid;
    logic [3:0] qry_x, qry_y;
    logic [1:0] qry_tile;
    logic       qry_tile_valid;
    logic       busy;
    logic       clear_done;
    logic       err_oob;
    logic [6:0] occ_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    snake_tile_map_ctrl dut (
        .clk(clk), .reset(reset), .game_done(game_done),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
        .upd_x(upd_x), .upd_y(upd_y), .upd_tile(upd_tile),
        .qry_valid(qry_valid), .qry_x(qry_x), .qry_y(qry_y),
        .qry_tile(qry_tile), .qry_tile_valid(qry_tile_valid),
        .busy(busy), .clear_done(clear_done), .err_oob(err_oob),
        .occ_count(occ_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid query response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && qry_tile_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL qry_unexpected: got tile %0d, expected no response", qry_tile);
            end else begin
                mon_exp = exp_q.pop_front();
                check("qry_tile", 32'(qry_tile), 32'(mon_exp));
            end
        end
    end

    task automatic query(input logic [3:0] x, input logic [3:0] y, input logic [1:0] e);
        qry_valid = 1'b1;
        qry_x     = x;
        qry_y     = y;
        exp_q.push_back(e);
        @(negedge clk);
        qry_valid = 1'b0;
    endtask

    // Present an update and hold it until accepted; returns on the negedge after acceptance.
    task automatic do_update(input logic op, input logic [3:0] x, input logic [3:0] y,
                             input logic [1:0] t);
        int waits;
        waits     = 0;
        upd_valid = 1'b1;
        upd_op    = op;
        upd_x     = x;
        upd_y     = y;
        upd_tile  = t;
        #1;
        while (!upd_ready && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 300) check("upd_accept_timeout", 32'(waits), 0);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic finish_write(input string name);
        for (int i = 0; i < W_CYC; i++) begin
            check({name, "_ready_low"}, 32'(upd_ready), 0);
            @(negedge clk);
        end
        check({name, "_ready_high"}, 32'(upd_ready), 1);
    endtask

    // Counts negedges until clear_done (bounded); also counts cycles where busy dropped early.
    task automatic wait_clear(output int k, output int busy_drop);
        k = 0;
        busy_drop = 0;
        do begin
            @(negedge clk);
            k++;
            if (!clear_done && !busy) busy_drop++;
        end while (!clear_done && k < 400);
    endtask

    logic [3:0] occ_x [5] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2};
    logic [1:0] occ_t [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    int         occ_e [5] = '{1, 2, 3, 3, 2};

    initial begin
        int k, bd;
        reset = 1'b1; game_done = 1'b0; upd_valid = 1'b0; upd_op = 1'b0;
        upd_x = '0; upd_y = '0; upd_tile = '0; qry_valid = 1'b0; qry_x = '0; qry_y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 1);
        check("rst_upd_ready", 32'(upd_ready), 0);
        check("rst_qry_valid", 32'(qry_tile_valid), 0);
        check("rst_qry_tile", 32'(qry_tile), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_err_oob", 32'(err_oob), 0);
        check("rst_occ", 32'(occ_count), 0);
        reset = 1'b0;

        // Power-on clear sweep
        wait_clear(k, bd);
        check("init_clear_len", 32'(k), 100);
        check("init_busy_held", 32'(bd), 0);
        check("init_ready_after", 32'(upd_ready), 1);
        check("init_busy_after", 32'(busy), 0);
        @(negedge clk);
        check("init_clear_done_pulse", 32'(clear_done), 0);
        query(4'd9, 4'd9, 2'd0);

        // Plain write and read-back
        do_update(1'b0, 4'd3, 4'd4, 2'd2);
        finish_write("wr34");
        query(4'd3, 4'd4, 2'd2);
        query(4'd4, 4'd3, 2'd0);

        // Write deferred by 20 back-to-back queries
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                upd_valid = 1'b1; upd_op = 1'b0; upd_x = 4'd5; upd_y = 4'd5; upd_tile = 2'd1;
            end
            qry_valid = 1'b1; qry_x = 4'd5; qry_y = 4'd5;
            exp_q.push_back(2'd0);
            @(negedge clk);
            if (i == 0) upd_valid = 1'b0;
        end
        check("defer_busy", 32'(busy), 1);
        check("defer_ready", 32'(upd_ready), 0);
        qry_valid = 1'b0;
        repeat (W_CYC) @(negedge clk);
        check("defer_done_ready", 32'(upd_ready), 1);
        check("defer_done_busy", 32'(busy), 0);
        query(4'd5, 4'd5, 2'd1);

        // Out-of-range write
        do_update(1'b0, 4'd10, 4'd2, 2'd3);
        check("oob_pulse", 32'(err_oob), 1);
        check("oob_ready", 32'(upd_ready), 1);
        @(negedge clk);
        check("oob_pulse_end", 32'(err_oob), 0);
        query(4'd10, 4'd2, 2'd0);
        query(4'd0, 4'd3, 2'd0);
        query(4'd15, 4'd15, 2'd0);
        query(4'd3, 4'd4, 2'd2);

        // game_done edge beats a simultaneous update
        game_done = 1'b1;
        upd_valid = 1'b1; upd_op = 1'b0; upd_x = 4'd7; upd_y = 4'd7; upd_tile = 2'd3;
        #1;
        check("gd_blocks_ready", 32'(upd_ready), 0);
        @(negedge clk);
        upd_valid = 1'b0;
        check("gd_busy", 32'(busy), 1);
        wait_clear(k, bd);
        check("gd_clear_len", 32'(k), 100);
        check("gd_busy_held", 32'(bd), 0);
        check("gd_ready_after", 32'(upd_ready), 1);
        game_done = 1'b0;
        query(4'd3, 4'd4, 2'd0);
        query(4'd5, 4'd5, 2'd0);
        query(4'd7, 4'd7, 2'd0);
        do_update(1'b0, 4'd7, 4'd7, 2'd3);
        finish_write("wr77");
        query(4'd7, 4'd7, 2'd3);
        check("occ_after_wr77", 32'(occ_count), OCC_EN ? 1 : 0);

        // CLEAR_ALL command
        do_update(1'b1, 4'd0, 4'd0, 2'd0);
        check("clrall_busy", 32'(busy), 1);
        wait_clear(k, bd);
        check("clrall_len", 32'(k), 100);
        check("clrall_occ", 32'(occ_count), 0);
        query(4'd7, 4'd7, 2'd0);

        // Occupancy tracking sequence
        for (int i = 0; i < 5; i++) begin
            do_update(1'b0, occ_x[i], 4'd1, occ_t[i]);
            finish_write("occ_wr");
            check("occ_count", 32'(occ_count), OCC_EN ? 32'(occ_e[i]) : 0);
        end
        query(4'd1, 4'd1, 2'd2);
        query(4'd2, 4'd1, 2'd0);
        query(4'd3, 4'd1, 2'd1);

        // game_done edge during WRITE: write finishes, then a full clear
        do_update(1'b0, 4'd4, 4'd4, 2'd3);
        game_done = 1'b1;
        wait_clear(k, bd);
        check("gdwr_clear_len", 32'(k), 101 + W_CYC);
        check("gdwr_busy_held", 32'(bd), 0);
        check("gdwr_occ", 32'(occ_count), 0);
        query(4'd4, 4'd4, 2'd0);
        query(4'd3, 4'd1, 2'd0);

        repeat (3) @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_tile_map_ctrl.md
Name: snake_tile_map_ctrl

Overview:
- Owns the tile-occupancy map (GRID_W x GRID_H tiles, 2 bits each) that the VGA path reads to colour 40-pixel board tiles.
- Arbitrates a single-port map between two users:
  - the renderer's per-pixel tile queries, which always win;
  - the game logic's tile writes and whole-map clears, which are deferred to query-free cycles.
- Sequences map clear on reset and on game_done.

Parameters:
- GRID_W, 10, board columns.
- GRID_H, 10, board rows.
- COORD_W, 4, width of x/y tile coordinates.
- CNT_W, 7, width of occupancy counter; must hold GRID_W*GRID_H.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- game_done  in  1  level from game logic; each rising edge requests a full clear.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  controller can accept an update.
- upd_op  in  1  0=WRITE tile, 1=CLEAR_ALL.
- upd_x  in  COORD_W  tile column for WRITE.
- upd_y  in  COORD_W  tile row for WRITE.
- upd_tile  in  2  tile code: 0 empty, 1 body, 2 head, 3 food.
- qry_valid  in  1  renderer query this cycle.
- qry_x  in  COORD_W  queried column.
- qry_y  in  COORD_W  queried row.
- qry_tile  out  2  tile code for the query issued the previous cycle.
- qry_tile_valid  out  1  qry_tile is valid (registered copy of qry_valid).
- busy  out  1  high while in WRITE or CLEAR, or while a clear is pending.
- clear_done  out  1  one-cycle pulse when a clear sweep finishes.
- err_oob  out  1  one-cycle pulse when an update is dropped as out of range.
- occ_count  out  CNT_W  count of non-empty tiles (OCC_COUNT_EN only; tied 0 otherwise).

Behaviour:
- Address: addr = y*GRID_W + x. Coordinates are in range iff x<GRID_W and y<GRID_H.
- Reset (async):
  - state=CLEAR, clr_ptr=0.
  - upd_ready=0, busy=1, qry_tile=0, qry_tile_valid=0, clear_done=0, err_oob=0, occ_count=0.
- Query path:
  - Registered read with 1-cycle latency; qry_tile_valid follows qry_valid by 1 cycle in every state.
  - An out-of-range query returns 0.
  - Queries never stall.
  - Map access is granted to the query whenever qry_valid=1.
- States:
  - IDLE:
    - upd_ready = !clr_pending && !gd_rise.
    - On handshake (upd_valid && upd_ready):
      - op=CLEAR_ALL -> CLEAR, clr_ptr=0.
      - op=WRITE, in range -> latch addr/tile, go to WRITE.
      - op=WRITE, out of range -> stay IDLE, err_oob=1 next cycle, map untouched.
    - If clr_pending or gd_rise: go to CLEAR and clear clr_pending.
  - WRITE:
    - upd_ready=0.
    - On the first cycle with qry_valid=0, write the latched tile and return to IDLE.
    - Best-case accept-to-accept spacing is 2 cycles.
  - CLEAR:
    - upd_ready=0.
    - Each cycle with qry_valid=0: write 0 at clr_ptr, then clr_ptr++.
    - After writing address GRID_W*GRID_H-1: go to IDLE, pulse clear_done, occ_count=0.
    - Minimum duration is GRID_W*GRID_H cycles.
- game_done:
  - gd_rise = game_done & ~game_done_d, using a 1-flop edge detector.
  - gd_rise in IDLE beats a simultaneous upd handshake; the update is not accepted.
  - gd_rise in WRITE sets clr_pending; the write completes first.
  - gd_rise in CLEAR restarts the sweep at clr_ptr=0.
- busy = (state!=IDLE) || clr_pending.
- Query and write never share a cycle, so no read-during-write bypass is needed. A query to the address of a deferred write returns the old value.
- Reset mid-WRITE or mid-CLEAR: the latched request is discarded and the sweep restarts from 0.

Optional Feature:
- Macro: SNAKE_TILE_OCC_COUNT_EN.
- With the macro defined, occ_count tracks non-empty tiles:
  - On each WRITE, read the old tile first; this read also needs a query-free cycle, so WRITE takes 2 free cycles.
  - +1 when empty->non-empty, -1 when non-empty->empty.
  - Set to 0 when CLEAR completes.
- Without the macro: occ_count=0 constant, and WRITE needs 1 free cycle.

Test Plan:
- Reset, qry_valid=0 throughout -> busy=1 for 100 cycles, clear_done pulses on cycle 100, upd_ready=1 next cycle; a query at (9,9) returns 0.
- WRITE (3,4) tile=2, qry_valid=0 -> upd_ready=0 one cycle, then 1; query (3,4) -> qry_tile=2 one cycle later; query (4,3) -> 0.
- WRITE (5,5) tile=1 with qry_valid held 1 for 20 cycles -> write deferred; a query to (5,5) during the hold returns 0; returns 1 after release.
- WRITE (10,2) -> err_oob pulses once, upd_ready back to 1, map unchanged; query (10,2) -> 0.
- game_done rises in the same cycle as a valid WRITE in IDLE -> update not accepted, full 100-cycle clear, clear_done pulse; update accepted after.
- SNAKE_TILE_OCC_COUNT_EN: write 3 body tiles, overwrite one with 2, overwrite one with 0 -> occ_count 1,2,3,3,2; CLEAR_ALL -> 0.
